load_store_unit: RTL
====================

# load_store_unit

Sequential load/store front end between the CPU execute stage and the word-addressed data memory. It accepts one byte-addressed load or store per handshake, checks alignment and range, and converts the byte address to a word index. Byte and halfword stores are done as read-modify-write, and load data is extracted and sign- or zero-extended. Results return through a valid/ready response channel.

## Interface
Parameters:
- `MEM_WORDS`, default 1024: data memory depth in 32-bit words; must be a power of two.
- `IDX_W`, default `$clog2(MEM_WORDS)`: word-index width (derived; do not override).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_unsigned`  in  1: zero-extend load result when 1.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer takes the response.
- `resp_rdata`  out  32: extended load data; 0 for stores and faults.
- `resp_fault`  out  1: misaligned, reserved-size, or out-of-range request.
- `mem_address`  out  32: word index, zero-extended from `IDX_W` bits.
- `mem_write_data`  out  32: full word to write.
- `mem_write_enable`  out  1: memory write strobe.
- `mem_read_data`  in  32: combinational read of `mem_address`.

## Operation
- FSM states: IDLE, LOAD, READ, WRITE, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch address, size, unsigned flag, write flag and wdata.
  - Then decode and transition:
    - Fault → RESP with fault = 1.
    - Load → LOAD.
    - Word store → WRITE.
    - Byte or half store → READ.
- Fault conditions:
  - `req_size` = 3.
  - Half with `addr[0]` = 1.
  - Word with `addr[1:0]` ≠ 0.
  - `addr[31:IDX_W+2]` ≠ 0.
  - A faulting request makes no memory access.
- Word index: `mem_address` = `addr[IDX_W+1:2]`, registered at accept and held until return to IDLE.
- LOAD:
  - Lane `l` = `addr[1:0]`; shifted = `mem_read_data >> (8*l)`.
  - Byte: bits [7:0], extended from bit 7. Half: bits [15:0], extended from bit 15. Word: unchanged.
  - Extension is zero when `req_unsigned` = 1, sign otherwise.
  - Register the result into `resp_rdata`, then go to RESP.
- READ: capture `mem_read_data` into the merge register, then go to WRITE.
- Store merge:
  - Byte: replace lane `l` with `wdata[7:0]`.
  - Half: replace lanes `l` and `l+1` with `wdata[15:0]`.
  - Word: `wdata` unchanged.
- WRITE: `mem_write_enable` = 1 for exactly this cycle, `mem_write_data` = merged word. Next state RESP.
- RESP:
  - `resp_valid` = 1, with `resp_rdata` and `resp_fault` held stable.
  - When `resp_ready` = 1, go to IDLE and clear `resp_rdata` and `resp_fault`.
- `req_ready` is 0 in every state except IDLE. No request is accepted while a response is pending.

## Timing
- `req_ready`, `resp_valid` and `mem_write_enable` are decoded from the state register only (no input-to-output combinational path).
- Accept edge E0. Earliest `resp_valid` high after:
  - fault: E0;
  - word store: E1 (memory written at E1);
  - load: E1;
  - byte/half store: E2 (memory written at E2).
- Back-to-back throughput: a new request can be accepted in the cycle after the response handshake.
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_fault` 0, `mem_address` 0, `mem_write_data` 0, `mem_write_enable` 0.
- Reset asserted mid-operation: return to IDLE immediately and drop `mem_write_enable` asynchronously. The in-flight request is discarded; no partial write, no response.
- `resp_ready` held high while in RESP: the response is consumed in one cycle.

## Structure
- Package `lsu_pkg`:
  - `lsu_size_e` (SIZE_B, SIZE_H, SIZE_W, SIZE_RSV).
  - `lsu_state_e` (IDLE, LOAD, READ, WRITE, RESP).
  - Constant `LSU_XLEN` = 32.
- Sub-module `lsu_align`: combinational load extract/extend and store merge. Inputs: lane, size, unsigned flag, memory word, wdata. Outputs: load value, merged word. The FSM top instantiates it once.

## Test plan
- Word store then load: store `addr` 0x10, `wdata` 0x12345678 → `mem_write_enable` one cycle with `mem_address` 4. Load `addr` 0x10 → `resp_rdata` 0x12345678, `resp_fault` 0.
- Byte RMW: memory word 4 = 0xAABBCCDD; store byte `addr` 0x12, `wdata` 0xFF → written 0xAAFFCCDD. `resp_valid` appears two edges after accept.
- Sign/zero extension: word = 0x0000_80F0. Byte load `addr` 0x0 signed → 0xFFFFFFF0; unsigned → 0x000000F0. Half load signed → 0xFFFF80F0.
- Faults:
  - Half `addr` 0x3 → `resp_fault` 1, `resp_rdata` 0, no write.
  - `req_size` 3 → fault.
  - `addr` 0x1000 with `MEM_WORDS` 1024 → fault.
- Backpressure: hold `resp_ready` 0 for 5 cycles → `resp_valid`/`resp_rdata` stable, `req_ready` 0 throughout, a presented `req_valid` is ignored.
- Reset in READ of a half store → `mem_write_enable` never pulses, memory unchanged, outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Access sizes, FSM states and the data-path width.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    typedef enum logic [1:0] {
        SIZE_B   = 2'd0,
        SIZE_H   = 2'd1,
        SIZE_W   = 2'd2,
        SIZE_RSV = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: load extract/extend and store merge into a memory word.
// Purely combinational; lane/size come from the latched request.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]          lane,
    input  lsu_size_e           size,
    input  logic                is_unsigned,
    input  logic [LSU_XLEN-1:0] word,
    input  logic [LSU_XLEN-1:0] wdata,
    output logic [LSU_XLEN-1:0] load_value,
    output logic [LSU_XLEN-1:0] merged
);

    logic [4:0]          sh;
    logic [LSU_XLEN-1:0] shifted;
    logic [LSU_XLEN-1:0] mask;
    logic [LSU_XLEN-1:0] ins;

    assign sh = {lane, 3'b000};

    always_comb begin
        shifted    = word >> sh;
        load_value = shifted;
        mask       = '1;
        ins        = wdata;
        case (size)
            SIZE_B: begin
                load_value = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
                mask       = 32'h0000_00FF << sh;
                ins        = {24'd0, wdata[7:0]} << sh;
            end
            SIZE_H: begin
                load_value = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
                mask       = 32'h0000_FFFF << sh;
                ins        = {16'd0, wdata[15:0]} << sh;
            end
            default: ;
        endcase
        merged = (word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end to a word-addressed data memory.
// Sub-word stores are read-modify-write; responses use valid/ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [31:0]         resp_rdata,
    output logic                resp_fault,
    output logic [31:0]         mem_address,
    output logic [31:0]         mem_write_data,
    output logic                mem_write_enable,
    input  logic [31:0]         mem_read_data
);

    lsu_state_e state;
    lsu_state_e state_nx;

    lsu_size_e  req_sz;
    logic       fault;
    logic       accept;

    logic [1:0]       lane_q;
    lsu_size_e        size_q;
    logic             uns_q;
    logic [31:0]      wdata_q;
    logic [IDX_W-1:0] idx_q;

    logic [31:0] load_value;
    logic [31:0] merged;

    assign req_sz      = lsu_size_e'(req_size);
    assign accept      = (state == IDLE) && req_valid;
    assign mem_address = {{(32-IDX_W){1'b0}}, idx_q};

    always_comb begin
        fault = (req_addr >> (IDX_W + 2)) != 32'd0;
        case (req_sz)
            SIZE_H:   if (req_addr[0]) fault = 1'b1;
            SIZE_W:   if (req_addr[1:0] != 2'b00) fault = 1'b1;
            SIZE_RSV: fault = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    priority case (1'b1)
                        fault:              state_nx = RESP;
                        !req_write:         state_nx = LOAD;
                        (req_sz == SIZE_W): state_nx = WRITE;
                        default:            state_nx = READ;
                    endcase
                end
            end
            LOAD:    state_nx = RESP;
            READ:    state_nx = WRITE;
            WRITE:   state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_write_enable = 1'b0;
        case (state)
            IDLE:    req_ready        = 1'b1;
            WRITE:   mem_write_enable = 1'b1;
            RESP:    resp_valid       = 1'b1;
            default: ;
        endcase
    end

    lsu_align u_align (
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .word        (mem_read_data),
        .wdata       (wdata_q),
        .load_value  (load_value),
        .merged      (merged)
    );

    // mem_write_data doubles as the merge register for sub-word stores
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q         <= 2'd0;
            size_q         <= SIZE_B;
            uns_q          <= 1'b0;
            wdata_q        <= 32'd0;
            idx_q          <= '0;
            resp_rdata     <= 32'd0;
            resp_fault     <= 1'b0;
            mem_write_data <= 32'd0;
        end else begin
            if (accept) begin
                lane_q     <= req_addr[1:0];
                size_q     <= req_sz;
                uns_q      <= req_unsigned;
                wdata_q    <= req_wdata;
                idx_q      <= req_addr[IDX_W+1:2];
                resp_rdata <= 32'd0;
                resp_fault <= fault;
                if (req_write && (req_sz == SIZE_W) && !fault)
                    mem_write_data <= req_wdata;
            end
            if (state == LOAD)
                resp_rdata <= load_value;
            if (state == READ)
                mem_write_data <= merged;
            if ((state == RESP) && resp_ready) begin
                resp_rdata <= 32'd0;
                resp_fault <= 1'b0;
            end
        end
    end

endmodule
